lcd_hd44780_ctrl: RTL and testbench

LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

---
 rtl/lcd_hd44780_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD write-only controller.
// Runs the timed power-on init sequence, then accepts instruction/data bytes
// from a host and drives them onto a 4- or 8-bit HD44780 bus. All delays
// are timed; the busy flag is never read.
module lcd_hd44780_ctrl #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BUS_W    = 4,
    parameter int TWO_LINE = 1,
    parameter int T_PWR_US = 15000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_rs,
    input  logic [7:0]       in_data,
    output logic             init_done,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic             lcd_en,
    output logic [BUS_W-1:0] lcd_data
);

    function automatic int atLeastOne(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int SETUP_CYC  = atLeastOne(CLK_HZ / 10_000_000);
    localparam int EN_CYC     = atLeastOne(CLK_HZ / 2_000_000);
    localparam int PWR_CYC    = atLeastOne(CYC_PER_US * T_PWR_US);
    localparam int W4100_CYC  = atLeastOne(CYC_PER_US * 4100);
    localparam int W1640_CYC  = atLeastOne(CYC_PER_US * 1640);
    localparam int W100_CYC   = atLeastOne(CYC_PER_US * 100);
    localparam int W40_CYC    = atLeastOne(CYC_PER_US * 40);
    localparam int MAX_CYC    = maxOf(maxOf(PWR_CYC, W4100_CYC), maxOf(SETUP_CYC, EN_CYC));
    localparam int CNT_W      = $clog2(MAX_CYC) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Each phase counts from 0 up to its "last" value, then moves on.
    localparam cnt_t PWR_LAST   = cnt_t'(PWR_CYC - 1);
    localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t EN_LAST    = cnt_t'(EN_CYC - 1);
    localparam cnt_t W4100_LAST = cnt_t'(W4100_CYC - 1);
    localparam cnt_t W1640_LAST = cnt_t'(W1640_CYC - 1);
    localparam cnt_t W100_LAST  = cnt_t'(W100_CYC - 1);
    localparam cnt_t W40_LAST   = cnt_t'(W40_CYC - 1);

    localparam logic [7:0] FUNC_SET  = {3'b001, (BUS_W == 8), (TWO_LINE != 0), 3'b000};
    localparam logic [3:0] LAST_STEP = 4'd8;

    typedef enum logic [2:0] {
        S_PWR,
        S_INIT,
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_EN_LO,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    cnt_t             waitLast_q, waitLast_d;
    logic [7:0]       txByte_q, txByte_d;
    logic             txRs_q, txRs_d;
    logic             singleStrobe_q, singleStrobe_d;
    logic             lowNibble_q, lowNibble_d;
    logic [3:0]       initStep_q, initStep_d;
    logic             initDone_q, initDone_d;
    logic             lcdEn_q, lcdRs_q;
    logic [BUS_W-1:0] lcdData_q;
    logic [BUS_W-1:0] strobeWord;
    logic [7:0]       initByte;

    // Clear and return-home need the long execution wait; everything else is short.
    function automatic cnt_t byteWaitLast(input logic rs, input logic [7:0] data);
        if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) begin
            return W1640_LAST;
        end
        return W40_LAST;
    endfunction

    generate
        if (BUS_W == 8) begin : gBus8
            assign strobeWord = txByte_d;
        end else if (BUS_W == 4) begin : gBus4
            assign strobeWord = lowNibble_d ? txByte_d[3:0] : txByte_d[7:4];
        end else begin : gBadBus
            $error("lcd_hd44780_ctrl: BUS_W must be 4 or 8");
        end
    endgenerate

    assign in_ready  = (state_q == S_IDLE) && initDone_q;
    assign init_done = initDone_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = lcdEn_q;
    assign lcd_rs    = lcdRs_q;
    assign lcd_data  = lcdData_q;

    // Next-state logic: phase timing, init step sequencing and host request capture.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + cnt_t'(1);
        waitLast_d     = waitLast_q;
        txByte_d       = txByte_q;
        txRs_d         = txRs_q;
        singleStrobe_d = singleStrobe_q;
        lowNibble_d    = lowNibble_q;
        initStep_d     = initStep_q;
        initDone_d     = initDone_q;
        initByte       = 8'h0C;

        case (state_q)
            S_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end

            S_INIT: begin
                case (initStep_q)
                    4'd0, 4'd1, 4'd2: initByte = 8'h30;
                    4'd3:             initByte = 8'h20;
                    4'd4:             initByte = FUNC_SET;
                    4'd5:             initByte = 8'h08;
                    4'd6:             initByte = 8'h01;
                    4'd7:             initByte = 8'h06;
                    default:          initByte = 8'h0C;
                endcase
                txByte_d       = initByte;
                txRs_d         = 1'b0;
                singleStrobe_d = (initStep_q < 4'd4);
                lowNibble_d    = 1'b0;
                case (initStep_q)
                    4'd0:       waitLast_d = W4100_LAST;
                    4'd1:       waitLast_d = W100_LAST;
                    4'd2, 4'd3: waitLast_d = W40_LAST;
                    default:    waitLast_d = byteWaitLast(1'b0, initByte);
                endcase
                state_d = S_SETUP;
                cnt_d   = '0;
            end

            S_IDLE: begin
                cnt_d = '0;
                if (in_valid && in_ready) begin
                    txByte_d       = in_data;
                    txRs_d         = in_rs;
                    singleStrobe_d = 1'b0;
                    lowNibble_d    = 1'b0;
                    waitLast_d     = byteWaitLast(in_rs, in_data);
                    state_d        = S_SETUP;
                end
            end

            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_EN_HI;
                    cnt_d   = '0;
                end
            end

            S_EN_HI: begin
                if (cnt_q == EN_LAST) begin
                    state_d = S_EN_LO;
                    cnt_d   = '0;
                end
            end

            S_EN_LO: begin
                if (cnt_q == EN_LAST) begin
                    cnt_d = '0;
                    if (BUS_W == 4 && !singleStrobe_q && !lowNibble_q) begin
                        lowNibble_d = 1'b1;
                        state_d     = S_SETUP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (cnt_q == waitLast_q) begin
                    cnt_d = '0;
                    if (initDone_q) begin
                        state_d = S_IDLE;
                    end else if (initStep_q == LAST_STEP) begin
                        initDone_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        initStep_d = (initStep_q == 4'd2 && BUS_W == 8) ? 4'd4 : initStep_q + 4'd1;
                        state_d    = S_INIT;
                    end
                end
            end

            default: begin
                state_d = S_PWR;
                cnt_d   = '0;
            end
        endcase
    end

    // State register plus registered bus pins, loaded from next-state so pins change with the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_PWR;
            cnt_q          <= '0;
            waitLast_q     <= '0;
            txByte_q       <= '0;
            txRs_q         <= 1'b0;
            singleStrobe_q <= 1'b0;
            lowNibble_q    <= 1'b0;
            initStep_q     <= '0;
            initDone_q     <= 1'b0;
            lcdEn_q        <= 1'b0;
            lcdRs_q        <= 1'b0;
            lcdData_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            waitLast_q     <= waitLast_d;
            txByte_q       <= txByte_d;
            txRs_q         <= txRs_d;
            singleStrobe_q <= singleStrobe_d;
            lowNibble_q    <= lowNibble_d;
            initStep_q     <= initStep_d;
            initDone_q     <= initDone_d;
            lcdEn_q        <= (state_d == S_EN_HI);
            if (state_d == S_SETUP || state_d == S_EN_HI || state_d == S_EN_LO) begin
                lcdData_q <= strobeWord;
                lcdRs_q   <= txRs_d;
            end
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed self-checking bench for lcd_hd44780_ctrl.
// A 4-bit and an 8-bit instance share clock and reset; a monitor per
// instance records every enable pulse (data, rs, rise/fall cycle).
// Runs at 4 MHz so one microsecond is 4 cycles: setup 1, enable 2,
// waits 16400/400/160/6560, power-on 80 cycles.
module tb_lcd_hd44780_ctrl;

    localparam int CLK_HZ    = 4_000_000;
    localparam int T_PWR_US  = 20;
    localparam int PWR_CYC   = 80;
    localparam int EN_CYC    = 2;
    localparam int W40_CYC   = 160;
    localparam int W100_CYC  = 400;
    localparam int W1640_CYC = 6560;
    localparam int W4100_CYC = 16400;
    // Power-on phase, then one S_INIT cycle and one setup cycle before enable rises.
    localparam int FIRST_RISE = PWR_CYC + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid, inRs;
    logic [7:0] inData;
    logic       inReady4, initDone4, lcdRs4, lcdRw4, lcdEn4;
    logic [3:0] lcdData4;
    logic       inValid8, inRs8;
    logic [7:0] inData8;
    logic       inReady8, initDone8, lcdRs8, lcdRw8, lcdEn8;
    logic [7:0] lcdData8;

    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;

    always #5 clk = ~clk;

    // Cycle counter used as the time base for all timing checks.
    always @(posedge clk) cyc <= cyc + 1;

    lcd_hd44780_ctrl #(.CLK_HZ(CLK_HZ), .BUS_W(4), .TWO_LINE(1), .T_PWR_US(T_PWR_US)) dut4 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady4), .in_rs(inRs),
        .in_data(inData), .init_done(initDone4), .lcd_rs(lcdRs4), .lcd_rw(lcdRw4),
        .lcd_en(lcdEn4), .lcd_data(lcdData4)
    );

    lcd_hd44780_ctrl #(.CLK_HZ(CLK_HZ), .BUS_W(8), .TWO_LINE(1), .T_PWR_US(T_PWR_US)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8), .in_rs(inRs8),
        .in_data(inData8), .init_done(initDone8), .lcd_rs(lcdRs8), .lcd_rw(lcdRw8),
        .lcd_en(lcdEn8), .lcd_data(lcdData8)
    );

    logic       prevEn4 = 1'b0;
    int         riseCyc4;
    logic [3:0] holdData4;
    logic       holdRs4;
    int         glitch4 = 0;
    logic [3:0] nib4Q[$];
    logic       rs4Q[$];
    int         rise4Q[$];
    int         fall4Q[$];

    // Records each 4-bit enable pulse and counts bus changes while enable is high.
    always @(negedge clk) begin
        if (lcdEn4 && !prevEn4) begin
            riseCyc4  = cyc;
            holdData4 = lcdData4;
            holdRs4   = lcdRs4;
        end else if (lcdEn4 && prevEn4) begin
            if (lcdData4 !== holdData4 || lcdRs4 !== holdRs4) glitch4++;
        end else if (!lcdEn4 && prevEn4) begin
            nib4Q.push_back(holdData4);
            rs4Q.push_back(holdRs4);
            rise4Q.push_back(riseCyc4);
            fall4Q.push_back(cyc);
        end
        prevEn4 = lcdEn4;
    end

    logic       prevEn8 = 1'b0;
    logic [7:0] byte8Q[$];
    logic       rs8Q[$];

    // Records each 8-bit enable pulse.
    always @(negedge clk) begin
        if (lcdEn8 && !prevEn8) begin
            byte8Q.push_back(lcdData8);
            rs8Q.push_back(lcdRs8);
        end
        prevEn8 = lcdEn8;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rs, input logic [7:0] data);
        inRs    = rs;
        inData  = data;
        inValid = 1'b1;
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return initDone4;
            1:       return initDone8;
            2:       return inReady4;
            3:       return lcdEn4;
            4:       return !lcdEn4;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitUntil(input int which, input int bound, input string tag, output int seenCyc);
        int n = 0;
        while (probe(which) !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        checkOutput({tag, " reached"}, 32'(probe(which)), 32'd1);
        seenCyc = cyc;
    endtask

    logic [3:0] expNib[14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0,
                               4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
    logic [7:0] expByte8[8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

    int t0, doneCyc, readyCyc, seen, base;

    initial begin
        rst = 1'b0;
        inValid = 1'b0; inRs = 1'b0; inData = 8'h00;
        inValid8 = 1'b0; inRs8 = 1'b0; inData8 = 8'h00;
        repeat (3) tick();

        checkOutput("reset lcd_en", 32'(lcdEn4), 32'd0);
        checkOutput("reset lcd_rs", 32'(lcdRs4), 32'd0);
        checkOutput("reset lcd_rw", 32'(lcdRw4), 32'd0);
        checkOutput("reset lcd_data", 32'(lcdData4), 32'd0);
        checkOutput("reset in_ready", 32'(inReady4), 32'd0);
        checkOutput("reset init_done", 32'(initDone4), 32'd0);
        checkOutput("reset lcd_en 8b", 32'(lcdEn8), 32'd0);
        checkOutput("reset lcd_data 8b", 32'(lcdData8), 32'd0);

        rst = 1'b1;
        t0  = cyc;
        $display("[TB] reset released, running 4-bit and 8-bit init");
        waitUntil(0, 30000, "init4 done", doneCyc);
        checkOutput("ready with init_done", 32'(inReady4), 32'd1);
        checkOutput("init4 strobe count", 32'(nib4Q.size()), 32'd14);
        if (nib4Q.size() >= 14) begin
            for (int i = 0; i < 14; i++) begin
                checkOutput($sformatf("init4 nibble %0d", i), 32'(nib4Q[i]), 32'(expNib[i]));
                checkOutput($sformatf("init4 rs %0d", i), 32'(rs4Q[i]), 32'd0);
                checkOutput($sformatf("init4 en width %0d", i), 32'(fall4Q[i] - rise4Q[i]), 32'(EN_CYC));
            end
            checkOutput("first en after power-on", 32'(rise4Q[0] - t0), 32'(FIRST_RISE));
            checkOutput("gap after 1st 0x3", 32'(rise4Q[1] - fall4Q[0]), 32'(EN_CYC + W4100_CYC + 2));
            checkOutput("gap after 2nd 0x3", 32'(rise4Q[2] - fall4Q[1]), 32'(EN_CYC + W100_CYC + 2));
            checkOutput("gap after 3rd 0x3", 32'(rise4Q[3] - fall4Q[2]), 32'(EN_CYC + W40_CYC + 2));
            checkOutput("gap after 0x2", 32'(rise4Q[4] - fall4Q[3]), 32'(EN_CYC + W40_CYC + 2));
            checkOutput("gap between nibbles", 32'(rise4Q[5] - fall4Q[4]), 32'(EN_CYC + 1));
            checkOutput("gap after clear", 32'(rise4Q[10] - fall4Q[9]), 32'(EN_CYC + W1640_CYC + 2));
            checkOutput("init_done after last wait", 32'(doneCyc - fall4Q[13]), 32'(EN_CYC + W40_CYC));
        end

        waitUntil(1, 30000, "init8 done", seen);
        checkOutput("init8 strobe count", 32'(byte8Q.size()), 32'd8);
        if (byte8Q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("init8 byte %0d", i), 32'(byte8Q[i]), 32'(expByte8[i]));
                checkOutput($sformatf("init8 rs %0d", i), 32'(rs8Q[i]), 32'd0);
            end
        end

        // Data byte 0x41, then hold a clear request while the controller is busy.
        base = nib4Q.size();
        applyStimulus(1'b1, 8'h41);
        tick();
        checkOutput("ready drops after accept", 32'(inReady4), 32'd0);
        applyStimulus(1'b0, 8'h01);
        waitUntil(2, 2000, "ready after 0x41", readyCyc);
        checkOutput("0x41 strobe count", 32'(nib4Q.size()), 32'(base + 2));
        if (nib4Q.size() >= base + 2) begin
            checkOutput("0x41 high nibble", 32'(nib4Q[base]), 32'h4);
            checkOutput("0x41 low nibble", 32'(nib4Q[base+1]), 32'h1);
            checkOutput("0x41 rs first", 32'(rs4Q[base]), 32'd1);
            checkOutput("0x41 rs second", 32'(rs4Q[base+1]), 32'd1);
            checkOutput("0x41 ready delay", 32'(readyCyc - fall4Q[base+1]), 32'(EN_CYC + W40_CYC));
        end
        tick();
        checkOutput("back-to-back accept", 32'(inReady4), 32'd0);
        applyStimulus(1'b1, 8'h55);
        waitUntil(2, 10000, "ready after clear", readyCyc);
        inValid = 1'b0;
        checkOutput("clear strobe count", 32'(nib4Q.size()), 32'(base + 4));
        if (nib4Q.size() >= base + 4) begin
            checkOutput("clear high nibble", 32'(nib4Q[base+2]), 32'h0);
            checkOutput("clear low nibble", 32'(nib4Q[base+3]), 32'h1);
            checkOutput("clear rs", 32'(rs4Q[base+3]), 32'd0);
            checkOutput("clear ready delay", 32'(readyCyc - fall4Q[base+3]), 32'(EN_CYC + W1640_CYC));
        end
        repeat (3) tick();
        checkOutput("no strobe when idle", 32'(nib4Q.size()), 32'(base + 4));
        checkOutput("no bus change while en high", 32'(glitch4), 32'd0);
        checkOutput("lcd_rw stays low", 32'(lcdRw4), 32'd0);

        // Reset in the middle of an enable pulse.
        applyStimulus(1'b1, 8'h48);
        waitUntil(3, 100, "en high of 0x48", seen);
        inValid = 1'b0;
        rst = 1'b0;
        tick();
        checkOutput("abort lcd_en", 32'(lcdEn4), 32'd0);
        checkOutput("abort init_done", 32'(initDone4), 32'd0);
        checkOutput("abort in_ready", 32'(inReady4), 32'd0);
        checkOutput("abort init_done 8b", 32'(initDone8), 32'd0);
        base = nib4Q.size();
        rst = 1'b1;
        t0  = cyc;
        waitUntil(3, 300, "re-init en rise", seen);
        waitUntil(4, 20, "re-init en fall", seen);
        checkOutput("re-init strobe count", 32'(nib4Q.size()), 32'(base + 1));
        if (nib4Q.size() >= base + 1) begin
            checkOutput("re-init first nibble", 32'(nib4Q[base]), 32'h3);
            checkOutput("re-init first rs", 32'(rs4Q[base]), 32'd0);
            checkOutput("re-init power-on delay", 32'(rise4Q[base] - t0), 32'(FIRST_RISE));
            checkOutput("re-init en width", 32'(fall4Q[base] - rise4Q[base]), 32'(EN_CYC));
        end
        checkOutput("re-init init_done low", 32'(initDone4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
